coprocessor_addr_seq: RTL and testbench
=======================================

// Module: coprocessor_addr_seq
// PURPOSE
//   Avalon-MM slave that generates the 15-bit coprocessor address stream without per-address CPU writes.
//   Nios writes BASE/LENGTH/STRIDE and then START; the block issues LENGTH addresses on cp_addr.
//   Addresses are BASE, BASE+STRIDE, ... with a valid/ready handshake to the coprocessor.
//   Sits between the Nios system interconnect and the coprocessor address input; supersedes the CPU-driven address PIO.
// PARAMETERS
//   ADDR_W    15  coprocessor address width
//   CNT_W     16  beat-count width (max LENGTH = 2^CNT_W-1)
//   STRIDE_W   8  address increment width (unsigned)
// PORTS
//   clk        in   1       system clock
//   reset      in   1       asynchronous reset, active-high
//   address    in   2       register select
//   chipselect in   1       slave select
//   write_n    in   1       active-low write strobe
//   writedata  in   32      write data
//   readdata   out  32      read data, combinational from address (zero wait states)
//   cp_addr    out  ADDR_W  current coprocessor address
//   cp_valid   out  1       cp_addr valid
//   cp_ready   in   1       coprocessor accepts beat this cycle
//   cp_last    out  1       current beat is the final beat of the run
//   irq        out  1       level interrupt to the CPU
// BEHAVIOUR
//   Clock and reset: one clock (clk); reset is asynchronous and active-high.
//   Reset: all outputs 0; BASE=0, LENGTH=0, STRIDE=1, done=0, aborted=0, irq_en=0, FSM=IDLE.
//   Register map (write = chipselect & ~write_n):
//     0 BASE[ADDR_W-1:0] RW; 1 LENGTH[CNT_W-1:0] RW; 2 STRIDE[STRIDE_W-1:0] RW.
//     3 CTRL/STATUS.
//       Write bits: b0 START, b1 ABORT, b2 CLR (clears done/aborted), b3 IRQ_EN (stored).
//       Read bits: b0 busy, b1 done, b2 aborted, b3 irq_en, [31:16] remaining beats.
//   Unused read bits are 0. Writes to 0..2 while busy are ignored, and reads return the stored values.
//   FSM IDLE -> RUN:
//     START in IDLE with LENGTH!=0 -> next edge: RUN, cp_valid=1, cp_addr=BASE, remaining=LENGTH.
//     START in IDLE with LENGTH==0 -> stays IDLE, done=1 next edge, no beats issued.
//     START while RUN is ignored.
//   RUN:
//     A beat transfers when cp_valid & cp_ready.
//     On a transfer: cp_addr += STRIDE, modulo 2^ADDR_W (wraps silently); remaining -= 1.
//     cp_addr and cp_valid hold stable while cp_valid & ~cp_ready.
//     cp_last = cp_valid & (remaining==1).
//     Transfer of the last beat -> next edge: IDLE, cp_valid=0, done=1.
//   Throughput: 1 beat/clk while cp_ready is held high. Latency from START write to first cp_valid is 1 clk.
//   ABORT in RUN -> next edge: IDLE, cp_valid=0, aborted=1, done=0.
//     This is the sole exception to the valid-stability rule.
//     A beat accepted in the ABORT cycle still counts.
//   ABORT in IDLE: no effect.
//   Same-cycle START+ABORT: ABORT wins and START is dropped.
//   Same-cycle CLR and last-beat completion: the set wins (done=1).
//   Reset mid-run: immediate IDLE, cp_valid=0, run lost.
// CONFIGURATION
//   COPROC_SEQ_IRQ_EN defined:
//     irq = irq_en & (done | aborted), registered.
//     Cleared by CLR or by writing IRQ_EN=0.
//   COPROC_SEQ_IRQ_EN undefined:
//     irq tied 0; IRQ_EN bit is not stored and reads 0.
//     Software polls the busy/done bits.
// STRUCTURE
//   Package coproc_seq_pkg:
//     register offsets (REG_BASE=0, REG_LEN=1, REG_STRIDE=2, REG_CTRL=3);
//     CTRL bit indices;
//     FSM state enum {IDLE, RUN}.
//   Sub-module coproc_addr_gen: address accumulator + remaining-beat down-counter.
//     Inputs: load/step/clear.
//     Outputs: cp_addr, remaining, last.
//   The top level holds the register file, the FSM, the readdata mux and the irq logic.
// TESTING
//   1. BASE=0x10, STRIDE=4, LENGTH=3, START, cp_ready=1
//      -> cp_addr 0x10,0x14,0x18 on consecutive clks; cp_last on 0x18; done=1; busy=0.
//   2. BASE=0x7FFE, STRIDE=1, LENGTH=4 -> cp_addr 0x7FFE,0x7FFF,0x0000,0x0001 (wrap).
//   3. cp_ready toggled 1-0-0-1 during a run -> cp_addr/cp_valid stable while stalled; no beat lost or duplicated.
//   4. LENGTH=0, START -> no cp_valid ever; done=1 after 1 clk.
//      With the macro and IRQ_EN=1: irq=1 until CLR.
//   5. ABORT after 2 of 10 beats -> cp_valid=0 next clk; aborted=1; remaining reads 8.
//      A BASE write during the run is ignored.
//   6. reset asserted mid-run -> all outputs 0 asynchronously; registers return to reset values.

Source files
------------

// File: rtl/coproc_seq_pkg.sv
// ============================================================================
// coproc_seq_pkg : register offsets, CTRL/STATUS bit indices and FSM states
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package coproc_seq_pkg;

   localparam logic [1:0] REG_BASE   = 2'd0;
   localparam logic [1:0] REG_LEN    = 2'd1;
   localparam logic [1:0] REG_STRIDE = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // CTRL write bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_CLR    = 2;
   localparam int CTRL_IRQ_EN = 3;

   // STATUS read bits
   localparam int STAT_BUSY       = 0;
   localparam int STAT_DONE       = 1;
   localparam int STAT_ABORTED    = 2;
   localparam int STAT_IRQ_EN     = 3;
   localparam int STAT_REMAIN_LSB = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/coproc_addr_gen.sv
// ============================================================================
// coproc_addr_gen : address accumulator plus remaining-beat down-counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module coproc_addr_gen
   import coproc_seq_pkg::*;
#(
   parameter int ADDR_W   = 15,
   parameter int CNT_W    = 16,
   parameter int STRIDE_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic                clear,
   input  logic [ADDR_W-1:0]   base,
   input  logic [CNT_W-1:0]    length,
   input  logic [STRIDE_W-1:0] stride,
   output logic [ADDR_W-1:0]   cp_addr,
   output logic [CNT_W-1:0]    remaining,
   output logic                last
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic [ADDR_W-1:0] w_stride_ext;

   assign w_stride_ext = ADDR_W'(stride);

   // clear only parks the address; the count is kept so software can see
   // how many beats an aborted run left behind
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if (load) begin
         r_addr      <= base;
         r_remaining <= length;
      end else begin
         if (clear)
            r_addr <= '0;
         else if (step)
            r_addr <= r_addr + w_stride_ext;
         if (step)
            r_remaining <= r_remaining - C_ONE;
      end
   end

   assign cp_addr   = r_addr;
   assign remaining = r_remaining;
   assign last      = (r_remaining == C_ONE);

endmodule

`default_nettype wire

// File: rtl/coprocessor_addr_seq.sv
// ============================================================================
// coprocessor_addr_seq : Avalon-MM slave issuing a strided coprocessor address
// stream. Optional interrupt enabled by defining COPROC_SEQ_IRQ_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module coprocessor_addr_seq
   import coproc_seq_pkg::*;
#(
   parameter int ADDR_W   = 15,
   parameter int CNT_W    = 16,
   parameter int STRIDE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] cp_addr,
   output logic              cp_valid,
   input  logic              cp_ready,
   output logic              cp_last,
   output logic              irq
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [CNT_W-1:0]    r_len;
   logic [STRIDE_W-1:0] r_stride;
   logic                r_done;
   logic                r_aborted;
   logic                w_done_nxt;
   logic                w_aborted_nxt;
   logic                w_irq_en;

   logic                w_wr;
   logic                w_ctrl_wr;
   logic                w_cfg_wr;
   logic                w_start;
   logic                w_abort;
   logic                w_clr;
   logic                w_busy;
   logic                w_beat;
   logic                w_load;
   logic                w_clear;
   logic                w_done_set;
   logic                w_abort_set;
   logic [CNT_W-1:0]    w_remaining;
   logic                w_last;
   logic                w_unused;

   assign w_wr      = chipselect & ~write_n;
   assign w_ctrl_wr = w_wr & (address == REG_CTRL);
   assign w_busy    = (r_state == RUN);
   assign w_cfg_wr  = w_wr & ~w_busy;
   assign w_start   = w_ctrl_wr & writedata[CTRL_START];
   assign w_abort   = w_ctrl_wr & writedata[CTRL_ABORT];
   assign w_clr     = w_ctrl_wr & writedata[CTRL_CLR];
   assign w_beat    = cp_valid & cp_ready;
   assign w_unused  = &{1'b0, writedata};

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_base   <= '0;
         r_len    <= '0;
         r_stride <= STRIDE_W'(1);
      end else if (w_cfg_wr) begin
         case (address)
            REG_BASE:   r_base   <= writedata[ADDR_W-1:0];
            REG_LEN:    r_len    <= writedata[CNT_W-1:0];
            REG_STRIDE: r_stride <= writedata[STRIDE_W-1:0];
            default:    ;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      w_done_set  = 1'b0;
      w_abort_set = 1'b0;
      case (r_state)
         IDLE: begin
            // ABORT in the same write drops START
            if (w_start && !w_abort) begin
               if (r_len != '0) begin
                  w_state_nxt = RUN;
                  w_load      = 1'b1;
               end else begin
                  w_done_set  = 1'b1;
               end
            end
         end
         RUN: begin
            if (w_abort) begin
               w_state_nxt = IDLE;
               w_clear     = 1'b1;
               w_abort_set = 1'b1;
            end else if (w_beat && w_last) begin
               w_state_nxt = IDLE;
               w_clear     = 1'b1;
               w_done_set  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Status flags: a set in the same cycle as CLR takes priority
   always_comb begin
      w_done_nxt    = r_done;
      w_aborted_nxt = r_aborted;
      if (w_done_set)
         w_done_nxt = 1'b1;
      else if (w_abort_set || w_clr)
         w_done_nxt = 1'b0;
      if (w_abort_set)
         w_aborted_nxt = 1'b1;
      else if (w_clr)
         w_aborted_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_done    <= w_done_nxt;
         r_aborted <= w_aborted_nxt;
      end
   end

   // ---------------------------------------------------------------- interrupt
`ifdef COPROC_SEQ_IRQ_EN
   logic r_irq_en;
   logic w_irq_en_nxt;
   logic r_irq;

   assign w_irq_en_nxt = w_ctrl_wr ? writedata[CTRL_IRQ_EN] : r_irq_en;

   // Built from next-state values so irq rises on the same edge as the flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_irq_en <= w_irq_en_nxt;
         r_irq    <= w_irq_en_nxt & (w_done_nxt | w_aborted_nxt);
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq      = r_irq;
`else
   assign w_irq_en = 1'b0;
   assign irq      = 1'b0;
`endif

   // ---------------------------------------------------------------- datapath
   coproc_addr_gen #(
      .ADDR_W   (ADDR_W),
      .CNT_W    (CNT_W),
      .STRIDE_W (STRIDE_W)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load),
      .step      (w_beat),
      .clear     (w_clear),
      .base      (r_base),
      .length    (r_len),
      .stride    (r_stride),
      .cp_addr   (cp_addr),
      .remaining (w_remaining),
      .last      (w_last)
   );

   assign cp_valid = w_busy;
   assign cp_last  = cp_valid & w_last;

   // ---------------------------------------------------------------- read mux
   always_comb begin
      readdata = '0;
      case (address)
         REG_BASE:   readdata[ADDR_W-1:0]   = r_base;
         REG_LEN:    readdata[CNT_W-1:0]    = r_len;
         REG_STRIDE: readdata[STRIDE_W-1:0] = r_stride;
         REG_CTRL: begin
            readdata[STAT_BUSY]                        = w_busy;
            readdata[STAT_DONE]                        = r_done;
            readdata[STAT_ABORTED]                     = r_aborted;
            readdata[STAT_IRQ_EN]                      = w_irq_en;
            readdata[STAT_REMAIN_LSB +: CNT_W]         = w_remaining;
         end
         default: readdata = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_coprocessor_addr_seq.sv
// ============================================================================
// tb_coprocessor_addr_seq : directed self-checking bench for coprocessor_addr_seq
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coprocessor_addr_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [14:0] cp_addr;
   logic        cp_valid;
   logic        cp_ready;
   logic        cp_last;
   logic        irq;

   int tests_run    = 0;
   int tests_failed = 0;

   coprocessor_addr_seq dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .cp_addr    (cp_addr),
      .cp_valid   (cp_valid),
      .cp_ready   (cp_ready),
      .cp_last    (cp_last),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Called at posedge+1; returns at posedge+1 after the write edge
   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      tests_run++;
      if ({cp_valid, cp_last, irq, cp_addr} !== 18'd0) begin
         $display("FAIL reset_outputs: got valid=%0b last=%0b irq=%0b addr=%h, expected all 0",
                  cp_valid, cp_last, irq, cp_addr);
         tests_failed++;
      end
      read_reg(2'd2, rd);
      tests_run++;
      if (rd !== 32'h1) begin
         $display("FAIL reset_stride: got %h expected %h", rd, 32'h1);
         tests_failed++;
      end
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== 32'h0) begin
         $display("FAIL reset_status: got %h expected %h", rd, 32'h0);
         tests_failed++;
      end
   endtask

   task automatic test_basic_run();
      logic [14:0] exp_addr [3] = '{15'h10, 15'h14, 15'h18};
      logic [31:0] rd;
      write_reg(2'd0, 32'h10);
      write_reg(2'd2, 32'h4);
      write_reg(2'd1, 32'h3);
      cp_ready = 1'b1;
      write_reg(2'd3, 32'h1);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (cp_valid !== 1'b1 || cp_addr !== exp_addr[i] || cp_last !== (i == 2)) begin
            $display("FAIL basic_beat%0d: got valid=%0b addr=%h last=%0b, expected 1 %h %0b",
                     i, cp_valid, cp_addr, cp_last, exp_addr[i], (i == 2));
            tests_failed++;
         end
         next_cycle();
      end
      tests_run++;
      if (cp_valid !== 1'b0) begin
         $display("FAIL basic_end_valid: got %0b expected 0", cp_valid);
         tests_failed++;
      end
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== 32'h2) begin
         $display("FAIL basic_status: got %h expected %h", rd, 32'h2);
         tests_failed++;
      end
   endtask

   task automatic test_wrap();
      logic [14:0] exp_addr [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      write_reg(2'd3, 32'h4);
      write_reg(2'd0, 32'h7FFE);
      write_reg(2'd2, 32'h1);
      write_reg(2'd1, 32'h4);
      cp_ready = 1'b1;
      write_reg(2'd3, 32'h1);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (cp_valid !== 1'b1 || cp_addr !== exp_addr[i] || cp_last !== (i == 3)) begin
            $display("FAIL wrap_beat%0d: got valid=%0b addr=%h last=%0b, expected 1 %h %0b",
                     i, cp_valid, cp_addr, cp_last, exp_addr[i], (i == 3));
            tests_failed++;
         end
         next_cycle();
      end
      tests_run++;
      if (cp_valid !== 1'b0) begin
         $display("FAIL wrap_end_valid: got %0b expected 0", cp_valid);
         tests_failed++;
      end
   endtask

   task automatic test_backpressure();
      logic [14:0] exp_addr [5] = '{15'h100, 15'h102, 15'h102, 15'h102, 15'h104};
      logic        rdy      [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] rd;
      write_reg(2'd3, 32'h4);
      write_reg(2'd0, 32'h100);
      write_reg(2'd2, 32'h2);
      write_reg(2'd1, 32'h3);
      cp_ready = 1'b0;
      write_reg(2'd3, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (cp_valid !== 1'b1 || cp_addr !== exp_addr[i] || cp_last !== (i == 4)) begin
            $display("FAIL stall_cycle%0d: got valid=%0b addr=%h last=%0b, expected 1 %h %0b",
                     i, cp_valid, cp_addr, cp_last, exp_addr[i], (i == 4));
            tests_failed++;
         end
         cp_ready = rdy[i];
         next_cycle();
      end
      read_reg(2'd3, rd);
      tests_run++;
      if (cp_valid !== 1'b0 || rd !== 32'h2) begin
         $display("FAIL stall_end: got valid=%0b status=%h, expected 0 %h", cp_valid, rd, 32'h2);
         tests_failed++;
      end
   endtask

   task automatic test_zero_length();
      logic [31:0] rd;
      logic [31:0] exp_st;
      logic [31:0] exp_st_clr;
      logic        exp_irq;
`ifdef COPROC_SEQ_IRQ_EN
      exp_st     = 32'hA;
      exp_st_clr = 32'h8;
      exp_irq    = 1'b1;
`else
      exp_st     = 32'h2;
      exp_st_clr = 32'h0;
      exp_irq    = 1'b0;
`endif
      write_reg(2'd3, 32'h4);
      write_reg(2'd1, 32'h0);
      cp_ready = 1'b1;
      write_reg(2'd3, 32'h9);
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== exp_st || irq !== exp_irq) begin
         $display("FAIL zero_len_done: got status=%h irq=%0b, expected %h %0b", rd, irq, exp_st, exp_irq);
         tests_failed++;
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (cp_valid !== 1'b0 || irq !== exp_irq) begin
            $display("FAIL zero_len_idle%0d: got valid=%0b irq=%0b, expected 0 %0b", i, cp_valid, irq, exp_irq);
            tests_failed++;
         end
         next_cycle();
      end
      write_reg(2'd3, 32'hC);
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== exp_st_clr || irq !== 1'b0) begin
         $display("FAIL zero_len_clr: got status=%h irq=%0b, expected %h 0", rd, irq, exp_st_clr);
         tests_failed++;
      end
      write_reg(2'd3, 32'h0);
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      write_reg(2'd3, 32'h4);
      write_reg(2'd0, 32'h20);
      write_reg(2'd2, 32'h1);
      write_reg(2'd1, 32'd10);
      cp_ready = 1'b1;
      write_reg(2'd3, 32'h1);
      write_reg(2'd0, 32'h55);
      tests_run++;
      if (cp_valid !== 1'b1 || cp_addr !== 15'h21) begin
         $display("FAIL abort_mid: got valid=%0b addr=%h, expected 1 %h", cp_valid, cp_addr, 15'h21);
         tests_failed++;
      end
      write_reg(2'd3, 32'h2);
      tests_run++;
      if (cp_valid !== 1'b0 || cp_last !== 1'b0) begin
         $display("FAIL abort_valid: got valid=%0b last=%0b, expected 0 0", cp_valid, cp_last);
         tests_failed++;
      end
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== 32'h0008_0004) begin
         $display("FAIL abort_status: got %h expected %h", rd, 32'h0008_0004);
         tests_failed++;
      end
      read_reg(2'd0, rd);
      tests_run++;
      if (rd !== 32'h20) begin
         $display("FAIL abort_base_locked: got %h expected %h", rd, 32'h20);
         tests_failed++;
      end
      // START and ABORT together in IDLE: nothing starts, nothing aborts
      write_reg(2'd3, 32'h4);
      write_reg(2'd3, 32'h3);
      read_reg(2'd3, rd);
      tests_run++;
      if (cp_valid !== 1'b0 || rd[3:0] !== 4'h0) begin
         $display("FAIL start_abort_same: got valid=%0b status=%h, expected 0 low nibble 0", cp_valid, rd);
         tests_failed++;
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] rd;
      write_reg(2'd0, 32'h30);
      write_reg(2'd1, 32'd5);
      cp_ready = 1'b1;
      write_reg(2'd3, 32'h1);
      next_cycle();
      tests_run++;
      if (cp_valid !== 1'b1 || cp_addr !== 15'h31) begin
         $display("FAIL prereset_run: got valid=%0b addr=%h, expected 1 %h", cp_valid, cp_addr, 15'h31);
         tests_failed++;
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if ({cp_valid, cp_last, irq, cp_addr} !== 18'd0) begin
         $display("FAIL async_reset_outputs: got valid=%0b last=%0b irq=%0b addr=%h, expected all 0",
                  cp_valid, cp_last, irq, cp_addr);
         tests_failed++;
      end
      read_reg(2'd0, rd);
      tests_run++;
      if (rd !== 32'h0) begin
         $display("FAIL async_reset_base: got %h expected %h", rd, 32'h0);
         tests_failed++;
      end
      next_cycle();
      reset = 1'b0;
      read_reg(2'd1, rd);
      tests_run++;
      if (rd !== 32'h0) begin
         $display("FAIL reset_len: got %h expected %h", rd, 32'h0);
         tests_failed++;
      end
      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== 32'h0 || cp_valid !== 1'b0) begin
         $display("FAIL reset_after_run: got status=%h valid=%0b, expected 0 0", rd, cp_valid);
         tests_failed++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      cp_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      next_cycle();
      test_basic_run();
      test_wrap();
      test_backpressure();
      test_zero_length();
      test_abort();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
